// File: rtl/alarm_pkg.sv
// Shared types and BCD helpers for the multi-channel alarm block.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZED = 2'd3
  } alarm_state_e;

  localparam logic [15:0] RING_DISP = 16'hAAAA;

  // BCD {m10,m1,s10,s1}; minutes wrap 59 -> 00 without touching seconds.
  function automatic logic [15:0] bcd_inc_min(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[11:8] >= 4'd9) begin
      r[11:8]  = 4'd0;
      r[15:12] = (t[15:12] >= 4'd5) ? 4'd0 : t[15:12] + 4'd1;
    end else begin
      r[11:8] = t[11:8] + 4'd1;
    end
    return r;
  endfunction

  // Seconds roll over 59 -> 00 and carry into the minutes field.
  function automatic logic [15:0] bcd_inc_sec(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] >= 4'd9) begin
      r[3:0] = 4'd0;
      if (t[7:4] >= 4'd5) begin
        r[7:4] = 4'd0;
        r      = bcd_inc_min(r);
      end else begin
        r[7:4] = t[7:4] + 4'd1;
      end
    end else begin
      r[3:0] = t[3:0] + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: setting register, edge-detected match, ring/snooze FSM.
module alarm_channel
  import alarm_pkg::*;
#(
  parameter logic [31:0] RING_CYCLES   = 32'd600_000_000,
  parameter logic [31:0] SNOOZE_CYCLES = 32'd300_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel_hit,
  input  logic        set_mode,
  input  logic        inc_sec,
  input  logic        inc_min,
  input  logic        arm_tgl,
  input  logic        ack,
  input  logic        snooze,
  input  logic [15:0] cur_time,
  output logic [15:0] setting,
  output logic        armed,
  output logic        ringing
);

  alarm_state_e state_q, state_d;
  logic [15:0]  setting_q, setting_d;
  logic [31:0]  ring_q, ring_d;
  logic [31:0]  snz_q, snz_d;
  logic         match_q, match_d;
  logic         trig;

  // NOTE: every variable gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    setting_d = setting_q;
    ring_d    = ring_q;
    snz_d     = snz_q;
    match_d   = (cur_time == setting_q);
    trig      = match_d & ~match_q;

    if (sel_hit && set_mode) begin
      if (inc_sec) setting_d = bcd_inc_sec(setting_d);
      if (inc_min) setting_d = bcd_inc_min(setting_d);
    end

    if (sel_hit && arm_tgl) begin
      state_d = (state_q == ST_IDLE) ? ST_ARMED : ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_ARMED: begin
          if (trig) begin
            state_d = ST_RINGING;
            ring_d  = RING_CYCLES - 32'd1;
          end
        end
        ST_RINGING: begin
          if (ack) begin
            state_d = ST_ARMED;
          end else if (snooze) begin
            state_d = ST_SNOOZED;
            snz_d   = SNOOZE_CYCLES - 32'd1;
          end else if (ring_q == 32'd0) begin
            state_d = ST_ARMED;
          end else begin
            ring_d = ring_q - 32'd1;
          end
        end
        ST_SNOOZED: begin
          if (ack) begin
            state_d = ST_ARMED;
          end else if (snz_q == 32'd0) begin
            state_d = ST_RINGING;
            ring_d  = RING_CYCLES - 32'd1;
          end else begin
            snz_d = snz_q - 32'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      setting_q <= 16'h0000;
      ring_q    <= 32'd0;
      snz_q     <= 32'd0;
      match_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      setting_q <= setting_d;
      ring_q    <= ring_d;
      snz_q     <= snz_d;
      match_q   <= match_d;
    end
  end

  assign setting = setting_q;
  assign armed   = (state_q != ST_IDLE);
  assign ringing = (state_q == ST_RINGING);

endmodule

// File: rtl/multi_alarm.sv
// N independent alarm channels sharing edit/arm controls and one display.
module multi_alarm
  import alarm_pkg::*;
#(
  parameter int          N_ALARMS      = 4,
  parameter logic [31:0] RING_CYCLES   = 32'd600_000_000,
  parameter logic [31:0] SNOOZE_CYCLES = 32'd300_000_000,
  localparam int         SW            = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SW-1:0]       sel,
  input  logic                set_mode,
  input  logic                inc_sec,
  input  logic                inc_min,
  input  logic                arm_tgl,
  input  logic                ack,
  input  logic                snooze,
  input  logic [15:0]         cur_time,
  output logic [15:0]         disp_time,
  output logic [N_ALARMS-1:0] armed,
  output logic [N_ALARMS-1:0] ringing,
  output logic                any_ring
);

  logic [N_ALARMS-1:0] sel_hit;
  logic [15:0]         setting [N_ALARMS];

  // Out-of-range sel values match no channel and are therefore ignored.
  for (genvar i = 0; i < N_ALARMS; i++) begin : g_ch
    assign sel_hit[i] = (sel == SW'(i));

    alarm_channel #(
      .RING_CYCLES  (RING_CYCLES),
      .SNOOZE_CYCLES(SNOOZE_CYCLES)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .sel_hit (sel_hit[i]),
      .set_mode(set_mode),
      .inc_sec (inc_sec),
      .inc_min (inc_min),
      .arm_tgl (arm_tgl),
      .ack     (ack),
      .snooze  (snooze),
      .cur_time(cur_time),
      .setting (setting[i]),
      .armed   (armed[i]),
      .ringing (ringing[i])
    );
  end

  assign any_ring = |ringing;

  always_comb begin
    disp_time = 16'h0000;
    for (int i = 0; i < N_ALARMS; i++) begin
      if (sel_hit[i]) disp_time = setting[i];
    end
    if (any_ring) disp_time = RING_DISP;
  end

endmodule

// File: tb/tb_multi_alarm.sv
// Directed bench for multi_alarm with short ring/snooze periods.
module tb_multi_alarm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sel;
  logic        set_mode, inc_sec, inc_min, arm_tgl, ack, snooze;
  logic [15:0] cur_time;
  logic [15:0] disp_time;
  logic [3:0]  armed, ringing;
  logic        any_ring;

  int checks = 0;
  int passed = 0;

  localparam logic [15:0] IDLE_TIME = 16'h4444;

  multi_alarm #(
    .N_ALARMS     (4),
    .RING_CYCLES  (32'd8),
    .SNOOZE_CYCLES(32'd5)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .sel      (sel),
    .set_mode (set_mode),
    .inc_sec  (inc_sec),
    .inc_min  (inc_min),
    .arm_tgl  (arm_tgl),
    .ack      (ack),
    .snooze   (snooze),
    .cur_time (cur_time),
    .disp_time(disp_time),
    .armed    (armed),
    .ringing  (ringing),
    .any_ring (any_ring)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic toggle_arm(input logic [1:0] ch);
    sel = ch; arm_tgl = 1'b1; step(1); arm_tgl = 1'b0;
  endtask

  task automatic add_sec(input logic [1:0] ch, input int n);
    sel = ch; set_mode = 1'b1; inc_sec = 1'b1; step(n);
    inc_sec = 1'b0; set_mode = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sel = 2'd0; set_mode = 0; inc_sec = 0; inc_min = 0;
    arm_tgl = 0; ack = 0; snooze = 0; cur_time = IDLE_TIME;
    step(2);
    checks++; if (armed !== 4'b0000) $display("FAIL rst_armed got=%b exp=%b", armed, 4'b0000); else passed++;
    checks++; if (ringing !== 4'b0000) $display("FAIL rst_ringing got=%b exp=%b", ringing, 4'b0000); else passed++;
    checks++; if (any_ring !== 1'b0) $display("FAIL rst_any_ring got=%b exp=0", any_ring); else passed++;
    checks++; if (disp_time !== 16'h0000) $display("FAIL rst_disp got=%h exp=0000", disp_time); else passed++;
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_edit;
    add_sec(2'd0, 59);
    checks++; if (disp_time !== 16'h0059) $display("FAIL edit_0059 got=%h exp=0059", disp_time); else passed++;
    add_sec(2'd0, 1);
    checks++; if (disp_time !== 16'h0100) $display("FAIL edit_sec_carry got=%h exp=0100", disp_time); else passed++;
    inc_sec = 1'b1; step(1); inc_sec = 1'b0;
    checks++; if (disp_time !== 16'h0100) $display("FAIL edit_no_mode got=%h exp=0100", disp_time); else passed++;
    set_mode = 1'b1; inc_min = 1'b1; step(58); inc_min = 1'b0; set_mode = 1'b0;
    add_sec(2'd0, 59);
    checks++; if (disp_time !== 16'h5959) $display("FAIL edit_5959 got=%h exp=5959", disp_time); else passed++;
    add_sec(2'd0, 1);
    checks++; if (disp_time !== 16'h0000) $display("FAIL edit_wrap got=%h exp=0000", disp_time); else passed++;
    set_mode = 1'b1; inc_sec = 1'b1; inc_min = 1'b1; step(30);
    inc_sec = 1'b0; step(29);
    checks++; if (disp_time !== 16'h5930) $display("FAIL edit_5930 got=%h exp=5930", disp_time); else passed++;
    step(1); inc_min = 1'b0; set_mode = 1'b0;
    checks++; if (disp_time !== 16'h0030) $display("FAIL edit_min_wrap got=%h exp=0030", disp_time); else passed++;
  endtask

  task automatic test_ring;
    add_sec(2'd2, 3);
    toggle_arm(2'd2);
    checks++; if (armed !== 4'b0100) $display("FAIL ring_armed got=%b exp=0100", armed); else passed++;
    for (int t = 0; t < 3; t++) begin
      cur_time = 16'(t); step(1);
    end
    checks++; if (ringing !== 4'b0000) $display("FAIL ring_early got=%b exp=0000", ringing); else passed++;
    cur_time = 16'h0003; step(1);
    checks++; if (ringing !== 4'b0100) $display("FAIL ring_start got=%b exp=0100", ringing); else passed++;
    checks++; if (disp_time !== 16'hAAAA) $display("FAIL ring_disp got=%h exp=aaaa", disp_time); else passed++;
    checks++; if (any_ring !== 1'b1) $display("FAIL ring_any got=%b exp=1", any_ring); else passed++;
    step(7);
    checks++; if (ringing !== 4'b0100) $display("FAIL ring_last got=%b exp=0100", ringing); else passed++;
    step(1);
    checks++; if (ringing !== 4'b0000) $display("FAIL ring_silence got=%b exp=0000", ringing); else passed++;
    checks++; if (armed !== 4'b0100) $display("FAIL ring_rearmed got=%b exp=0100", armed); else passed++;
    checks++; if (disp_time !== 16'h0003) $display("FAIL ring_disp_after got=%h exp=0003", disp_time); else passed++;
    cur_time = IDLE_TIME;
    toggle_arm(2'd2);
  endtask

  task automatic test_snooze;
    toggle_arm(2'd0);
    cur_time = 16'h0030; step(1);
    checks++; if (ringing !== 4'b0001) $display("FAIL snz_ring got=%b exp=0001", ringing); else passed++;
    snooze = 1'b1; step(1); snooze = 1'b0;
    checks++; if (ringing !== 4'b0000) $display("FAIL snz_quiet got=%b exp=0000", ringing); else passed++;
    checks++; if (armed !== 4'b0001) $display("FAIL snz_armed got=%b exp=0001", armed); else passed++;
    step(4);
    checks++; if (ringing !== 4'b0000) $display("FAIL snz_still_quiet got=%b exp=0000", ringing); else passed++;
    step(1);
    checks++; if (ringing !== 4'b0001) $display("FAIL snz_rering got=%b exp=0001", ringing); else passed++;
    ack = 1'b1; step(1); ack = 1'b0;
    checks++; if (ringing !== 4'b0000 || armed !== 4'b0001)
      $display("FAIL snz_ack got=%b/%b exp=0000/0001", ringing, armed); else passed++;
    step(10);
    checks++; if (ringing !== 4'b0000) $display("FAIL snz_no_retrig got=%b exp=0000", ringing); else passed++;
    cur_time = IDLE_TIME;
    toggle_arm(2'd0);
  endtask

  task automatic test_back_to_back;
    add_sec(2'd1, 5);
    add_sec(2'd3, 5);
    toggle_arm(2'd1);
    toggle_arm(2'd3);
    cur_time = 16'h0005; step(1);
    checks++; if (ringing !== 4'b1010) $display("FAIL dual_ring got=%b exp=1010", ringing); else passed++;
    ack = 1'b1; snooze = 1'b1; step(1); ack = 1'b0; snooze = 1'b0;
    checks++; if (ringing !== 4'b0000 || armed !== 4'b1010)
      $display("FAIL dual_ack got=%b/%b exp=0000/1010", ringing, armed); else passed++;
    step(6);
    checks++; if (ringing !== 4'b0000) $display("FAIL dual_ack_wins got=%b exp=0000", ringing); else passed++;
  endtask

  task automatic test_edit_snoozed;
    toggle_arm(2'd1);
    cur_time = IDLE_TIME; step(1);
    cur_time = 16'h0005; step(1);
    checks++; if (ringing !== 4'b1000) $display("FAIL es_ring got=%b exp=1000", ringing); else passed++;
    snooze = 1'b1; step(1); snooze = 1'b0;
    add_sec(2'd3, 1);
    checks++; if (disp_time !== 16'h0006) $display("FAIL es_disp got=%h exp=0006", disp_time); else passed++;
    step(3);
    checks++; if (ringing !== 4'b0000) $display("FAIL es_quiet got=%b exp=0000", ringing); else passed++;
    step(1);
    checks++; if (ringing !== 4'b1000 || disp_time !== 16'hAAAA)
      $display("FAIL es_rering got=%b/%h exp=1000/aaaa", ringing, disp_time); else passed++;
  endtask

  task automatic test_reset_mid_ring;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ringing !== 4'b0000 || any_ring !== 1'b0)
      $display("FAIL mr_async got=%b/%b exp=0000/0", ringing, any_ring); else passed++;
    checks++; if (armed !== 4'b0000) $display("FAIL mr_armed got=%b exp=0000", armed); else passed++;
    checks++; if (disp_time !== 16'h0000) $display("FAIL mr_disp got=%h exp=0000", disp_time); else passed++;
    @(negedge clk);
    cur_time = 16'h0000;
    rst_n = 1'b1;
    step(3);
    checks++; if (ringing !== 4'b0000 || armed !== 4'b0000)
      $display("FAIL mr_no_trig got=%b/%b exp=0000/0000", ringing, armed); else passed++;
    checks++; if (disp_time !== 16'h0000) $display("FAIL mr_setting got=%h exp=0000", disp_time); else passed++;
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_edit;
    test_ring;
    test_snooze;
    test_back_to_back;
    test_edit_snoozed;
    test_reset_mid_ring;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
